// File: rtl/gelato_warp_issue.sv
// Warp issue stage: round-robin selection of hazard-free warp heads, checked against a
// per-warp scoreboard view, feeding one registered valid/ready issue slot.
module gelato_warp_issue #(
  parameter int unsigned WARP_NUM = 4,
  parameter int unsigned SB_SIZE  = 4,
  parameter int unsigned REG_W    = 5,
  localparam int unsigned WID     = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rdy,
  input  logic [WARP_NUM-1:0]               ibuf_valid,
  input  logic [WARP_NUM*REG_W-1:0]         ibuf_rs1,
  input  logic [WARP_NUM*REG_W-1:0]         ibuf_rs2,
  input  logic [WARP_NUM*REG_W-1:0]         ibuf_rd,
  input  logic [WARP_NUM*32-1:0]            ibuf_inst,
  output logic [WARP_NUM-1:0]               ibuf_pop,
  input  logic [WARP_NUM*SB_SIZE*REG_W-1:0] sb_regs,
  output logic [REG_W-1:0]                  sb_new_reg,
  output logic [WID-1:0]                    sb_warp_num,
  output logic                              issue_valid,
  input  logic                              issue_ready,
  output logic [WID-1:0]                    issue_warp,
  output logic [31:0]                       issue_inst,
  output logic [REG_W-1:0]                  issue_rs1,
  output logic [REG_W-1:0]                  issue_rs2,
  output logic [REG_W-1:0]                  issue_rd
);

  logic [REG_W-1:0]    rs1_w  [WARP_NUM];
  logic [REG_W-1:0]    rs2_w  [WARP_NUM];
  logic [REG_W-1:0]    rd_w   [WARP_NUM];
  logic [31:0]         inst_w [WARP_NUM];
  logic [WARP_NUM-1:0] hazard;
  logic [WARP_NUM-1:0] sb_full;
  logic [WARP_NUM-1:0] eligible;

  logic                can_select;
  logic                sel_valid;
  logic [WID-1:0]      sel_warp;
  logic [WID-1:0]      rr_ptr_q, rr_ptr_d;

  logic                issue_valid_q;
  logic [WID-1:0]      issue_warp_q;
  logic [31:0]         issue_inst_q;
  logic [REG_W-1:0]    issue_rs1_q, issue_rs2_q, issue_rd_q;

  for (genvar w = 0; w < WARP_NUM; w++) begin : g_warp
    logic [SB_SIZE-1:0] slot_used;
    logic [SB_SIZE-1:0] slot_hit;

    assign rs1_w[w]  = ibuf_rs1[w*REG_W +: REG_W];
    assign rs2_w[w]  = ibuf_rs2[w*REG_W +: REG_W];
    assign rd_w[w]   = ibuf_rd[w*REG_W +: REG_W];
    assign inst_w[w] = ibuf_inst[w*32 +: 32];

    for (genvar s = 0; s < SB_SIZE; s++) begin : g_slot
      logic [REG_W-1:0] slot;
      assign slot         = sb_regs[(w*SB_SIZE+s)*REG_W +: REG_W];
      assign slot_used[s] = |slot;
      // A used slot is nonzero, so a match can never be against register 0.
      assign slot_hit[s]  = slot_used[s] &&
                            ((rs1_w[w] == slot) || (rs2_w[w] == slot) || (rd_w[w] == slot));
    end

    assign hazard[w]   = |slot_hit;
    assign sb_full[w]  = (rd_w[w] != '0) && (&slot_used);
    assign eligible[w] = ibuf_valid[w] && !hazard[w] && !sb_full[w];
  end

  // Selection is blocked while the issue slot holds an instruction the consumer has not taken.
  assign can_select = rst_n && rdy && (!issue_valid_q || issue_ready);

  always_comb begin
    int unsigned idx;
    sel_valid = 1'b0;
    sel_warp  = '0;
    idx       = 0;
    for (int unsigned k = 0; k < WARP_NUM; k++) begin
      idx = (32'(rr_ptr_q) + k) % WARP_NUM;
      if (can_select && !sel_valid && eligible[WID'(idx)]) begin
        sel_valid = 1'b1;
        sel_warp  = WID'(idx);
      end
    end
  end

  always_comb begin
    if (32'(sel_warp) == WARP_NUM - 1) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = sel_warp + WID'(1);
    end
  end

  always_comb begin
    ibuf_pop    = '0;
    sb_new_reg  = '0;
    sb_warp_num = '0;
    if (sel_valid) begin
      ibuf_pop[sel_warp] = 1'b1;
      sb_new_reg         = rd_w[sel_warp];
      sb_warp_num        = sel_warp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      issue_valid_q <= 1'b0;
      issue_warp_q  <= '0;
      issue_inst_q  <= '0;
      issue_rs1_q   <= '0;
      issue_rs2_q   <= '0;
      issue_rd_q    <= '0;
    end else if (rdy) begin
      if (sel_valid) begin
        rr_ptr_q      <= rr_ptr_d;
        issue_valid_q <= 1'b1;
        issue_warp_q  <= sel_warp;
        issue_inst_q  <= inst_w[sel_warp];
        issue_rs1_q   <= rs1_w[sel_warp];
        issue_rs2_q   <= rs2_w[sel_warp];
        issue_rd_q    <= rd_w[sel_warp];
      end else if (issue_valid_q && issue_ready) begin
        issue_valid_q <= 1'b0;
      end
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_warp  = issue_warp_q;
  assign issue_inst  = issue_inst_q;
  assign issue_rs1   = issue_rs1_q;
  assign issue_rs2   = issue_rs2_q;
  assign issue_rd    = issue_rd_q;

  a_sel_warp_range: assert property (@(posedge clk) disable iff (!rst_n)
    sel_valid |-> (32'(sel_warp) < WARP_NUM));
  a_sel_fields_known: assert property (@(posedge clk) disable iff (!rst_n)
    sel_valid |-> !$isunknown({inst_w[sel_warp], rs1_w[sel_warp], rs2_w[sel_warp],
                               rd_w[sel_warp]}));
  a_issue_warp_range: assert property (@(posedge clk) disable iff (!rst_n)
    issue_valid_q |-> (32'(issue_warp_q) < WARP_NUM));

endmodule

// File: tb/tb_gelato_warp_issue.sv
// Self-checking bench for gelato_warp_issue: directed scenarios plus a randomized run
// against a behavioural model of round-robin issue over an emulated scoreboard.
module tb_gelato_warp_issue;
  localparam int N  = 4;
  localparam int S  = 4;
  localparam int RW = 5;

  logic              clk = 1'b0;
  logic              rst_n, rdy, issue_ready;
  logic [N-1:0]      ibuf_valid;
  logic [N*RW-1:0]   ibuf_rs1, ibuf_rs2, ibuf_rd;
  logic [N*32-1:0]   ibuf_inst;
  logic [N-1:0]      ibuf_pop;
  logic [N*S*RW-1:0] sb_regs;
  logic [RW-1:0]     sb_new_reg;
  logic [1:0]        sb_warp_num;
  logic              issue_valid;
  logic [1:0]        issue_warp;
  logic [31:0]       issue_inst;
  logic [RW-1:0]     issue_rs1, issue_rs2, issue_rd;

  int n_cmp = 0;
  int n_err = 0;

  // Environment: instruction-buffer heads and scoreboard contents per warp.
  bit            h_v   [N];
  logic [RW-1:0] h_rs1 [N];
  logic [RW-1:0] h_rs2 [N];
  logic [RW-1:0] h_rd  [N];
  logic [31:0]   h_inst[N];
  logic [RW-1:0] sb    [N][S];

  gelato_warp_issue #(.WARP_NUM(N), .SB_SIZE(S), .REG_W(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .ibuf_valid (ibuf_valid),
    .ibuf_rs1   (ibuf_rs1),
    .ibuf_rs2   (ibuf_rs2),
    .ibuf_rd    (ibuf_rd),
    .ibuf_inst  (ibuf_inst),
    .ibuf_pop   (ibuf_pop),
    .sb_regs    (sb_regs),
    .sb_new_reg (sb_new_reg),
    .sb_warp_num(sb_warp_num),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_warp (issue_warp),
    .issue_inst (issue_inst),
    .issue_rs1  (issue_rs1),
    .issue_rs2  (issue_rs2),
    .issue_rd   (issue_rd)
  );

  always #5 clk = ~clk;

  task automatic drive();
    for (int w = 0; w < N; w++) begin
      ibuf_valid[w]            = h_v[w];
      ibuf_rs1[w*RW +: RW]     = h_rs1[w];
      ibuf_rs2[w*RW +: RW]     = h_rs2[w];
      ibuf_rd[w*RW +: RW]      = h_rd[w];
      ibuf_inst[w*32 +: 32]    = h_inst[w];
      for (int s = 0; s < S; s++) sb_regs[(w*S+s)*RW +: RW] = sb[w][s];
    end
  endtask

  task automatic clear_env();
    for (int w = 0; w < N; w++) begin
      h_v[w] = 1'b0; h_rs1[w] = '0; h_rs2[w] = '0; h_rd[w] = '0; h_inst[w] = '0;
      for (int s = 0; s < S; s++) sb[w][s] = '0;
    end
  endtask

  task automatic set_head(input int w, input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                          input logic [RW-1:0] rd, input logic [31:0] inst);
    h_v[w] = 1'b1; h_rs1[w] = r1; h_rs2[w] = r2; h_rd[w] = rd; h_inst[w] = inst;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rdy = 1'b1; issue_ready = 1'b1;
    clear_env();
    drive();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [49:0] pl;
    logic [10:0] sel;
    clear_env();
    for (int w = 0; w < N; w++) set_head(w, '0, '0, RW'(w + 1), 32'hA000_0000 + w);
    rdy = 1'b1; issue_ready = 1'b0; rst_n = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    pl = {issue_valid, issue_warp, issue_inst, issue_rs1, issue_rs2, issue_rd};
    n_cmp++;
    if (pl !== '0) begin
      n_err++; $display("FAIL reset_payload: got %h want 0", pl);
    end
    sel = {ibuf_pop, sb_new_reg, sb_warp_num};
    n_cmp++;
    if (sel !== '0) begin
      n_err++; $display("FAIL reset_select: got %h want 0", sel);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    sel = {ibuf_pop, sb_new_reg, sb_warp_num};
    n_cmp++;
    if (sel !== {4'b0001, 5'd1, 2'd0}) begin
      n_err++; $display("FAIL reset_first_select: got %h want %h", sel, {4'b0001, 5'd1, 2'd0});
    end
    step();
    @(negedge clk);
    pl = {issue_valid, issue_warp, issue_inst, issue_rs1, issue_rs2, issue_rd};
    n_cmp++;
    if (pl !== {1'b1, 2'd0, 32'hA000_0000, 5'd0, 5'd0, 5'd1}) begin
      n_err++; $display("FAIL reset_first_issue: got %h", pl);
    end
    n_cmp++;
    if (ibuf_pop !== 4'b0000) begin
      n_err++; $display("FAIL reset_hold_nopop: got %b want 0000", ibuf_pop);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [10:0] sel, exp_sel;
    logic [49:0] pl, exp_pl;
    int pw;
    do_reset();
    for (int w = 0; w < N; w++) set_head(w, '0, '0, RW'(w + 1), 32'hA000_0000 + w);
    drive();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_sel = {4'(1 << (c % 4)), 5'(c % 4 + 1), 2'(c % 4)};
      sel = {ibuf_pop, sb_new_reg, sb_warp_num};
      n_cmp++;
      if (sel !== exp_sel) begin
        n_err++; $display("FAIL rr_select c%0d: got %h want %h", c, sel, exp_sel);
      end
      exp_pl = '0;
      if (c > 0) begin
        pw = (c - 1) % 4;
        exp_pl = {1'b1, 2'(pw), 32'hA000_0000 + pw, 5'd0, 5'd0, 5'(pw + 1)};
      end
      pl = {issue_valid, issue_warp, issue_inst, issue_rs1, issue_rs2, issue_rd};
      n_cmp++;
      if (pl !== exp_pl) begin
        n_err++; $display("FAIL rr_issue c%0d: got %h want %h", c, pl, exp_pl);
      end
      step();
    end
  endtask

  task automatic test_raw_skip();
    logic [10:0] sel;
    logic [49:0] pl;
    do_reset();
    set_head(0, 5'd5, '0, '0, 32'hB000_0000);
    sb[0][0] = 5'd5;
    set_head(1, '0, '0, '0, 32'hB000_0001);
    drive();
    @(negedge clk);
    sel = {ibuf_pop, sb_new_reg, sb_warp_num};
    n_cmp++;
    if (sel !== {4'b0010, 5'd0, 2'd1}) begin
      n_err++; $display("FAIL raw_pick_w1: got %h want %h", sel, {4'b0010, 5'd0, 2'd1});
    end
    step();
    h_v[1] = 1'b0;
    drive();
    @(negedge clk);
    n_cmp++;
    if ({ibuf_pop, sb_new_reg} !== '0) begin
      n_err++; $display("FAIL raw_skip_w0: got %b/%h want 0", ibuf_pop, sb_new_reg);
    end
    pl = {issue_valid, issue_warp, issue_inst, issue_rs1, issue_rs2, issue_rd};
    n_cmp++;
    if (pl !== {1'b1, 2'd1, 32'hB000_0001, 15'd0}) begin
      n_err++; $display("FAIL raw_issue_w1: got %h", pl);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({ibuf_pop, issue_valid} !== 5'b0) begin
      n_err++; $display("FAIL raw_still_blocked: got pop=%b valid=%b want 0", ibuf_pop,
                        issue_valid);
    end
    step();
    sb[0][0] = '0;
    drive();
    @(negedge clk);
    sel = {ibuf_pop, sb_new_reg, sb_warp_num};
    n_cmp++;
    if (sel !== {4'b0001, 5'd0, 2'd0}) begin
      n_err++; $display("FAIL raw_release_w0: got %h want %h", sel, {4'b0001, 5'd0, 2'd0});
    end
    step();
    @(negedge clk);
    pl = {issue_valid, issue_warp, issue_inst, issue_rs1, issue_rs2, issue_rd};
    n_cmp++;
    if (pl !== {1'b1, 2'd0, 32'hB000_0000, 5'd5, 5'd0, 5'd0}) begin
      n_err++; $display("FAIL raw_issue_w0: got %h", pl);
    end
    step();
  endtask

  task automatic test_record_raw();
    logic [10:0] sel;
    logic [49:0] pl;
    do_reset();
    set_head(2, '0, '0, 5'd7, 32'hC000_0002);
    drive();
    @(negedge clk);
    sel = {ibuf_pop, sb_new_reg, sb_warp_num};
    n_cmp++;
    if (sel !== {4'b0100, 5'd7, 2'd2}) begin
      n_err++; $display("FAIL rec_select: got %h want %h", sel, {4'b0100, 5'd7, 2'd2});
    end
    step();
    sb[2][0] = 5'd7;
    set_head(2, 5'd7, '0, '0, 32'hC000_0012);
    drive();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({ibuf_pop, sb_new_reg} !== '0) begin
        n_err++; $display("FAIL rec_raw_block c%0d: got %b/%h want 0", c, ibuf_pop, sb_new_reg);
      end
      if (c == 0) begin
        pl = {issue_valid, issue_warp, issue_inst, issue_rs1, issue_rs2, issue_rd};
        n_cmp++;
        if (pl !== {1'b1, 2'd2, 32'hC000_0002, 5'd0, 5'd0, 5'd7}) begin
          n_err++; $display("FAIL rec_issue: got %h", pl);
        end
      end
      step();
    end
    sb[2][0] = '0;
    drive();
    @(negedge clk);
    sel = {ibuf_pop, sb_new_reg, sb_warp_num};
    n_cmp++;
    if (sel !== {4'b0100, 5'd0, 2'd2}) begin
      n_err++; $display("FAIL rec_release: got %h want %h", sel, {4'b0100, 5'd0, 2'd2});
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [10:0] sel;
    logic [49:0] pl;
    do_reset();
    set_head(0, '0, '0, 5'd9, 32'hD000_0000);
    set_head(1, '0, '0, 5'd10, 32'hD000_0001);
    issue_ready = 1'b0;
    drive();
    @(negedge clk);
    sel = {ibuf_pop, sb_new_reg, sb_warp_num};
    n_cmp++;
    if (sel !== {4'b0001, 5'd9, 2'd0}) begin
      n_err++; $display("FAIL bp_first: got %h want %h", sel, {4'b0001, 5'd9, 2'd0});
    end
    step();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) issue_ready = 1'b1;
      @(negedge clk);
      sel = {ibuf_pop, sb_new_reg, sb_warp_num};
      n_cmp++;
      if (c < 3 && sel[10:2] !== '0) begin
        n_err++; $display("FAIL bp_stall c%0d: got %h want 0", c, sel[10:2]);
      end else if (c == 3 && sel !== {4'b0010, 5'd10, 2'd1}) begin
        n_err++; $display("FAIL bp_handoff_select: got %h want %h", sel, {4'b0010, 5'd10, 2'd1});
      end
      pl = {issue_valid, issue_warp, issue_inst, issue_rs1, issue_rs2, issue_rd};
      n_cmp++;
      if (pl !== {1'b1, 2'd0, 32'hD000_0000, 5'd0, 5'd0, 5'd9}) begin
        n_err++; $display("FAIL bp_hold c%0d: got %h", c, pl);
      end
      step();
    end
    issue_ready = 1'b0;
    @(negedge clk);
    pl = {issue_valid, issue_warp, issue_inst, issue_rs1, issue_rs2, issue_rd};
    n_cmp++;
    if (pl !== {1'b1, 2'd1, 32'hD000_0001, 5'd0, 5'd0, 5'd10}) begin
      n_err++; $display("FAIL bp_reload: got %h", pl);
    end
    step();
  endtask

  task automatic test_sb_full();
    logic [10:0] sel;
    logic [49:0] pl;
    do_reset();
    set_head(1, '0, '0, 5'd3, 32'hE000_0001);
    sb[1][0] = 5'd1; sb[1][1] = 5'd2; sb[1][2] = 5'd4; sb[1][3] = 5'd6;
    drive();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({ibuf_pop, sb_new_reg} !== '0) begin
        n_err++; $display("FAIL full_stall c%0d: got %b/%h want 0", c, ibuf_pop, sb_new_reg);
      end
      step();
    end
    set_head(1, 5'd8, '0, '0, 32'hE000_0011);
    drive();
    @(negedge clk);
    sel = {ibuf_pop, sb_new_reg, sb_warp_num};
    n_cmp++;
    if (sel !== {4'b0010, 5'd0, 2'd1}) begin
      n_err++; $display("FAIL full_rd0_select: got %h want %h", sel, {4'b0010, 5'd0, 2'd1});
    end
    step();
    @(negedge clk);
    pl = {issue_valid, issue_warp, issue_inst, issue_rs1, issue_rs2, issue_rd};
    n_cmp++;
    if (pl !== {1'b1, 2'd1, 32'hE000_0011, 5'd8, 5'd0, 5'd0}) begin
      n_err++; $display("FAIL full_rd0_issue: got %h", pl);
    end
    step();
  endtask

  task automatic test_freeze_reset();
    logic [10:0] sel;
    logic [49:0] pl;
    do_reset();
    for (int w = 0; w < N; w++) set_head(w, '0, '0, RW'(w + 1), 32'hF000_0000 + w);
    drive();
    step();
    @(negedge clk);
    sel = {ibuf_pop, sb_new_reg, sb_warp_num};
    n_cmp++;
    if (sel !== {4'b0010, 5'd2, 2'd1}) begin
      n_err++; $display("FAIL frz_pre: got %h want %h", sel, {4'b0010, 5'd2, 2'd1});
    end
    step();
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rdy = 1'b1;
      @(negedge clk);
      sel = {ibuf_pop, sb_new_reg, sb_warp_num};
      n_cmp++;
      if (c < 2 && sel[10:2] !== '0) begin
        n_err++; $display("FAIL frz_nopop c%0d: got %h want 0", c, sel[10:2]);
      end else if (c == 2 && sel !== {4'b0100, 5'd3, 2'd2}) begin
        n_err++; $display("FAIL frz_resume: got %h want %h", sel, {4'b0100, 5'd3, 2'd2});
      end
      pl = {issue_valid, issue_warp, issue_inst, issue_rs1, issue_rs2, issue_rd};
      n_cmp++;
      if (pl !== {1'b1, 2'd1, 32'hF000_0001, 5'd0, 5'd0, 5'd2}) begin
        n_err++; $display("FAIL frz_hold c%0d: got %h", c, pl);
      end
      step();
    end
    rst_n = 1'b0;
    @(negedge clk);
    pl = {issue_valid, issue_warp, issue_inst, issue_rs1, issue_rs2, issue_rd};
    sel = {ibuf_pop, sb_new_reg, sb_warp_num};
    n_cmp++;
    if ({pl, sel} !== '0) begin
      n_err++; $display("FAIL frz_midreset: got %h/%h want 0", pl, sel);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    sel = {ibuf_pop, sb_new_reg, sb_warp_num};
    n_cmp++;
    if (sel !== {4'b0001, 5'd1, 2'd0}) begin
      n_err++; $display("FAIL frz_rr_reset: got %h want %h", sel, {4'b0001, 5'd1, 2'd0});
    end
    step();
  endtask

  function automatic bit m_hazard(input int w);
    for (int s = 0; s < S; s++)
      if (sb[w][s] != 0 && (sb[w][s] == h_rs1[w] || sb[w][s] == h_rs2[w] || sb[w][s] == h_rd[w]))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_full(input int w);
    int used = 0;
    for (int s = 0; s < S; s++) if (sb[w][s] != 0) used++;
    return (h_rd[w] != 0) && (used == S);
  endfunction

  task automatic new_head(input int w);
    set_head(w, RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
             $urandom);
  endtask

  task automatic test_random();
    int          m_rr, sel;
    bit          m_iv, placed;
    logic [49:0] m_pl, pl, exp_pl;
    logic [10:0] got_sel, exp_sel;
    do_reset();
    m_rr = 0; m_iv = 1'b0; m_pl = '0;
    for (int w = 0; w < N; w++) new_head(w);
    for (int cyc = 0; cyc < 600; cyc++) begin
      rdy         = ($urandom_range(0, 9) != 0);
      issue_ready = ($urandom_range(0, 9) < 7);
      drive();
      sel = -1;
      if (rdy && (!m_iv || issue_ready)) begin
        for (int k = 0; k < N; k++) begin
          int w;
          w = (m_rr + k) % N;
          if (sel < 0 && h_v[w] && !m_hazard(w) && !m_full(w)) sel = w;
        end
      end
      exp_sel = '0;
      if (sel >= 0) exp_sel = {4'(1 << sel), h_rd[sel], 2'(sel)};
      exp_pl = m_iv ? m_pl : '0;
      @(negedge clk);
      got_sel = {ibuf_pop, sb_new_reg, sb_warp_num};
      if (sel < 0) got_sel[1:0] = 2'b0;
      n_cmp++;
      if (got_sel !== exp_sel) begin
        n_err++; $display("FAIL rand_select cyc%0d: got %h want %h", cyc, got_sel, exp_sel);
      end
      pl = {issue_valid, issue_warp, issue_inst, issue_rs1, issue_rs2, issue_rd};
      if (!m_iv) pl[48:0] = '0;
      n_cmp++;
      if (pl !== exp_pl) begin
        n_err++; $display("FAIL rand_issue cyc%0d: got %h want %h", cyc, pl, exp_pl);
      end
      @(posedge clk);
      if (rdy) begin
        if (sel >= 0) begin
          m_iv = 1'b1;
          m_pl = {1'b1, 2'(sel), h_inst[sel], h_rs1[sel], h_rs2[sel], h_rd[sel]};
          m_rr = (sel + 1) % N;
        end else if (m_iv && issue_ready) begin
          m_iv = 1'b0;
        end
      end
      #1;
      // Writeback drains slots at random; the issued destination then becomes dirty.
      for (int w = 0; w < N; w++)
        for (int s = 0; s < S; s++)
          if (sb[w][s] != 0 && $urandom_range(0, 3) == 0) sb[w][s] = '0;
      if (sel >= 0) begin
        placed = 1'b0;
        if (h_rd[sel] != 0)
          for (int s = 0; s < S; s++)
            if (!placed && sb[sel][s] == 0) begin
              sb[sel][s] = h_rd[sel];
              placed = 1'b1;
            end
        new_head(sel);
      end
      for (int w = 0; w < N; w++) if (w != sel) h_v[w] = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b0; issue_ready = 1'b0;
    clear_env();
    drive();
    test_reset();
    test_round_robin();
    test_raw_skip();
    test_record_raw();
    test_backpressure();
    test_sb_full();
    test_freeze_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
